// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU memory slave and its SRAM array.
// Parity support is compiled in with the GPU_MEM_SLAVE_PARITY_EN macro.
package gpu_pkg;

  typedef enum logic {
    INIT,
    RUN
  } mem_state_e;

  localparam int MEM_IDX_LSB = 2;
  localparam int MEM_IDX_MSB = 13;

  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/gpu_sram_array.sv
// Synchronous single-port RAM with a registered, write-first read port.
// The read register only updates on a read, so its output holds between reads.
module gpu_sram_array
  import gpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
  end

  // A simultaneous read and write of the same word returns the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (i_re) begin
      rdata_q <= i_we ? i_wdata : mem_q[i_addr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/gpu_mem_slave.sv
// On-chip memory slave: zero-fills after reset, then serves one access per cycle.
// Define GPU_MEM_SLAVE_PARITY_EN to store and check an even-parity bit per word.
module gpu_mem_slave
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_init_done,
  output logic                  o_drop,
  output logic                  o_parity_err
);

  localparam int AW     = $clog2(DEPTH);
  localparam int IDX_W  = MEM_IDX_MSB - MEM_IDX_LSB + 1;
`ifdef GPU_MEM_SLAVE_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  mem_state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic rvalid_q, drop_q;
  logic rd_accept, drop_d;

  logic [IDX_W-1:0] idx;
  logic in_range;
  logic unused_addr_bits;

  logic ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata, req_word;

  assign idx      = i_addr[MEM_IDX_MSB:MEM_IDX_LSB];
  assign in_range = ({1'b0, idx} < (IDX_W+1)'(DEPTH));
  assign unused_addr_bits = ^{i_addr[ADDR_WIDTH-1:MEM_IDX_MSB+1], i_addr[MEM_IDX_LSB-1:0]};

`ifdef GPU_MEM_SLAVE_PARITY_EN
  assign req_word = {even_parity(i_wdata), i_wdata};
`else
  assign req_word = i_wdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rd_accept;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && cnt_q == AW'(DEPTH - 1)) begin
      state_d = RUN;
    end
  end

  // INIT owns the RAM port for the fill; any request seen then is dropped.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = idx[AW-1:0];
    ram_wdata = req_word;
    cnt_d     = cnt_q;
    rd_accept = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_addr  = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + AW'(1);
        drop_d    = i_req;
      end
      RUN: begin
        if (i_req) begin
          if (in_range) begin
            ram_we    = i_we;
            ram_re    = ~i_we;
            rd_accept = ~i_we;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  gpu_sram_array #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (ram_we),
    .i_re    (ram_re),
    .i_addr  (ram_addr),
    .i_wdata (ram_wdata),
    .o_rdata (ram_rdata)
  );

  assign o_rdata     = ram_rdata[DATA_WIDTH-1:0];
  assign o_rvalid    = rvalid_q;
  assign o_drop      = drop_q;
  assign o_init_done = (state_q == RUN);

`ifdef GPU_MEM_SLAVE_PARITY_EN
  assign o_parity_err = rvalid_q &
                        (even_parity(ram_rdata[DATA_WIDTH-1:0]) != ram_rdata[DATA_WIDTH]);
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_mem_slave.sv
// Directed testbench for gpu_mem_slave with DEPTH=16.
// Covers init timing, drops, read/write, back-to-back reads and reset mid-operation.
module tb_gpu_mem_slave;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_init_done;
  logic        o_drop;
  logic        o_parity_err;

  int total = 0;
  int bad   = 0;
  int cycles;

  gpu_mem_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (req),
    .i_we         (we),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_rdata      (o_rdata),
    .o_rvalid     (o_rvalid),
    .o_init_done  (o_init_done),
    .o_drop       (o_drop),
    .o_parity_err (o_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] d);
    req   = r;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic waitInit(output int n);
    n = 0;
    while (!o_init_done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    #12;
    checkOutput("rst_rdata", o_rdata, 32'h0);
    checkOutput("rst_rvalid", {31'b0, o_rvalid}, 32'h0);
    checkOutput("rst_init_done", {31'b0, o_init_done}, 32'h0);
    checkOutput("rst_drop", {31'b0, o_drop}, 32'h0);
    checkOutput("rst_perr", {31'b0, o_parity_err}, 32'h0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cycles = 0;
    while (!o_init_done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 10) begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h0000_0000;
        wdata = 32'hBAD0_BAD0;
      end
      if (cycles == 11) begin
        checkOutput("init_drop", {31'b0, o_drop}, 32'h1);
        req = 1'b0;
        we  = 1'b0;
      end
      if (cycles == 12) checkOutput("init_drop_clear", {31'b0, o_drop}, 32'h0);
    end
    checkOutput("init_cycles", cycles, 32'd16);
    checkOutput("init_done", {31'b0, o_init_done}, 32'h1);

    applyStimulus(1'b1, 1'b0, 32'h0000_0014, 32'h0);
    checkOutput("rd5_valid", {31'b0, o_rvalid}, 32'h1);
    checkOutput("rd5_data", o_rdata, 32'h0);
    checkOutput("rd5_drop", {31'b0, o_drop}, 32'h0);

    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    checkOutput("rd0_after_init_req", o_rdata, 32'h0);

    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    checkOutput("wr4_no_valid", {31'b0, o_rvalid}, 32'h0);
    checkOutput("wr4_rdata_hold", o_rdata, 32'h0);

    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    checkOutput("rd4_valid", {31'b0, o_rvalid}, 32'h1);
    checkOutput("rd4_data", o_rdata, 32'hDEAD_BEEF);

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("idle_valid", {31'b0, o_rvalid}, 32'h0);
    checkOutput("idle_hold", o_rdata, 32'hDEAD_BEEF);
    checkOutput("idle_drop", {31'b0, o_drop}, 32'h0);

    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    checkOutput("oor_rd_drop", {31'b0, o_drop}, 32'h1);
    checkOutput("oor_rd_valid", {31'b0, o_rvalid}, 32'h0);
    checkOutput("oor_rd_hold", o_rdata, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
    checkOutput("oor_wr_drop", {31'b0, o_drop}, 32'h1);

    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    checkOutput("rd0_no_alias", o_rdata, 32'h0);
    checkOutput("rd0_drop_clear", {31'b0, o_drop}, 32'h0);

    applyStimulus(1'b1, 1'b0, 32'h0000_4010, 32'h0);
    checkOutput("rd_sel_bits", o_rdata, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 1'b1, 32'h0000_0004, 32'h11);
    applyStimulus(1'b1, 1'b1, 32'h0000_0008, 32'h22);
    applyStimulus(1'b1, 1'b1, 32'h0000_000C, 32'h33);
    applyStimulus(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    checkOutput("b2b1_valid", {31'b0, o_rvalid}, 32'h1);
    checkOutput("b2b1_data", o_rdata, 32'h11);
    applyStimulus(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    checkOutput("b2b2_valid", {31'b0, o_rvalid}, 32'h1);
    checkOutput("b2b2_data", o_rdata, 32'h22);
    applyStimulus(1'b1, 1'b0, 32'h0000_000C, 32'h0);
    checkOutput("b2b3_valid", {31'b0, o_rvalid}, 32'h1);
    checkOutput("b2b3_data", o_rdata, 32'h33);
    checkOutput("b2b3_perr", {31'b0, o_parity_err}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("b2b_end_valid", {31'b0, o_rvalid}, 32'h0);

`ifdef GPU_MEM_SLAVE_PARITY_EN
    applyStimulus(1'b1, 1'b1, 32'h0000_001C, 32'h0000_0000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    dut.u_sram.mem_q[7] = dut.u_sram.mem_q[7] ^ 33'h1;
    applyStimulus(1'b1, 1'b0, 32'h0000_001C, 32'h0);
    checkOutput("par_valid", {31'b0, o_rvalid}, 32'h1);
    checkOutput("par_data", o_rdata, 32'h1);
    checkOutput("par_err", {31'b0, o_parity_err}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("par_err_clear", {31'b0, o_parity_err}, 32'h0);
`else
    applyStimulus(1'b1, 1'b0, 32'h0000_001C, 32'h0);
    checkOutput("nopar_valid", {31'b0, o_rvalid}, 32'h1);
    checkOutput("nopar_err", {31'b0, o_parity_err}, 32'h0);
`endif

    applyStimulus(1'b1, 1'b1, 32'h0000_0018, 32'hCAFE_F00D);
    applyStimulus(1'b1, 1'b0, 32'h0000_0018, 32'h0);
    checkOutput("rd6_valid", {31'b0, o_rvalid}, 32'h1);
    checkOutput("rd6_data", o_rdata, 32'hCAFE_F00D);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'b0, o_rvalid}, 32'h0);
    checkOutput("midrst_rdata", o_rdata, 32'h0);
    checkOutput("midrst_init_done", {31'b0, o_init_done}, 32'h0);
    req = 1'b0;
    we  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitInit(cycles);
    checkOutput("reinit_cycles", cycles, 32'd16);
    applyStimulus(1'b1, 1'b0, 32'h0000_0018, 32'h0);
    checkOutput("reinit_rd6_valid", {31'b0, o_rvalid}, 32'h1);
    checkOutput("reinit_rd6_data", o_rdata, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
